frame_buf_sched: RTL and testbench
==================================

# frame_buf_sched

Single-clock multi-buffer frame scheduler that sits between a pixel producer, a pixel consumer and one shared `data_mem` instance partitioned into `NUM_BUFS` frame slots. It tracks ownership of every slot (free, being written, ready, being read), grants whole frames to the writer and the reader, and generates the memory enables and addresses. The reader always receives the newest completed frame. Stale completed frames are dropped and counted.

## Interface
- `DATA_WIDTH`, 24, pixel width.
- `ADDR_WIDTH`, 3, pixel-index width; frame length is `1 << ADDR_WIDTH` pixels.
- `NUM_BUFS`, 3, number of frame slots, legal range 2..4.
- `BUF_WIDTH`, 2, slot-index width; must satisfy `1 << BUF_WIDTH >= NUM_BUFS`.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_req`  in  1  producer requests to start a frame (level).
- `wr_valid`  in  1  pixel valid on `wr_data` during a granted write frame.
- `wr_data`  in  DATA_WIDTH  pixel.
- `wr_grant`  out  1  one-cycle pulse: write frame accepted.
- `rd_req`  in  1  consumer requests a frame (level).
- `rd_en_in`  in  1  consumer takes one pixel during a granted read frame.
- `rd_grant`  out  1  one-cycle pulse: read frame accepted.
- `mem_wr_en`  out  1  active-low write enable to `data_mem`.
- `mem_wr_addr`  out  BUF_WIDTH+ADDR_WIDTH  `{slot, pixel}`.
- `mem_wr_data`  out  DATA_WIDTH  registered copy of `wr_data`.
- `mem_rd_en`  out  1  active-low read enable to `data_mem`.
- `mem_rd_addr`  out  BUF_WIDTH+ADDR_WIDTH  `{slot, pixel}`.
- `frame_ready`  out  1  high while a READY slot exists.
- `drop_cnt`  out  8  count of dropped frames, saturating at 255.

## Operation
- Each slot holds one state: FREE, WRITING, READY or READING. At most one slot is READY at any time.
- **Writer FSM: W_IDLE.**
  - When `wr_req` = 1 and some slot is FREE (registered state), take the lowest-index FREE slot.
  - That slot goes to WRITING, the write pixel counter clears to 0, `wr_grant` pulses, and the FSM moves to W_FILL.
  - With no FREE slot, stay in W_IDLE with `wr_grant` = 0 until one frees.
  - `wr_valid` is ignored in W_IDLE.
- **Writer FSM: W_FILL.**
  - Each cycle with `wr_valid` = 1 writes one pixel at `{slot, cnt}` and increments `cnt`.
  - `wr_req` is ignored in W_FILL.
  - On the pixel with `cnt == all-ones`, the slot becomes READY and the FSM returns to W_IDLE.
  - If another slot was READY at that moment, that older slot becomes FREE and `drop_cnt` increments.
- **Reader FSM: R_IDLE.**
  - When `rd_req` = 1 and a READY slot exists, that slot becomes READING, the read counter clears to 0, `rd_grant` pulses, and the FSM moves to R_READ.
- **Reader FSM: R_READ.**
  - Each cycle with `rd_en_in` = 1 issues one read at `{slot, cnt}` and increments `cnt`.
  - After the all-ones pixel is issued, the slot becomes FREE and the FSM returns to R_IDLE.
- With `NUM_BUFS` ≥ 3 the writer is never blocked. With `NUM_BUFS` = 2 the writer stalls while one slot is READING and the other is READY.
- **Reset (at any time, including mid-frame):**
  - All slots FREE; both FSMs idle.
  - `wr_grant`, `rd_grant`, `frame_ready` = 0; `mem_wr_en`, `mem_rd_en` = 1 (deasserted).
  - Both addresses 0; `mem_wr_data` 0; `drop_cnt` 0.
  - Any partial frame is discarded.

## Timing
- All outputs are registered.
- `wr_req` sampled at edge N gives `wr_grant` high in cycle N+1. The first `wr_valid` is accepted from edge N+1 onward.
- `wr_valid` sampled at edge N drives `mem_wr_en` = 0 with `mem_wr_addr` and `mem_wr_data` valid in cycle N+1. The write pipeline latency is 1 cycle.
- `rd_en_in` sampled at edge N drives `mem_rd_en` = 0 with `mem_rd_addr` in cycle N+1. Data then appears per `data_mem` read latency.
- Slot state changes take effect at the edge that processes them. The other FSM sees them one cycle later. Examples:
  - A READY produced at edge N is grantable to the reader at edge N+1.
  - A slot freed by the reader at edge N is grantable to the writer at edge N+1.
- Writer completes at the same edge the reader grants the old READY slot: the reader takes the old slot. The new frame becomes READY with no drop, because the old slot is no longer READY.
- `frame_ready` updates one cycle after the slot-state change.
- Pixel counters wrap only through frame completion. The FSM exits on the all-ones pixel, so a counter never overflows into the next frame.
- `drop_cnt` saturates at 255.

## Test plan
All scenarios use `NUM_BUFS` = 3 and `ADDR_WIDTH` = 3, i.e. 8-pixel frames.
- **Reset:** hold `reset` for 2 cycles mid-W_FILL.
  - Expect all outputs at reset values, `frame_ready` = 0, and the next `wr_req` granted slot 0 at `mem_wr_addr` = 0x00.
- **Single frame:** write 8 pixels 0..7 into slot 0 (addresses 0x00..0x07), then `rd_req`.
  - Expect `rd_grant` one cycle after `frame_ready`, then read addresses 0x00..0x07 with `mem_rd_en` low for exactly 8 cycles.
- **Drop:** write frames A (slot 0) and B (slot 1) with no reader.
  - Expect slot 0 freed when B completes, `drop_cnt` = 1, and the next read using slot 1 (addresses 0x08..0x0F).
- **Concurrent streams:** reading slot 0 while writing slot 1, with `wr_valid` and `rd_en_in` toggled pseudo-randomly.
  - Expect no address collision between slots, 8 writes and 8 reads each, and correct `{slot, pixel}` sequences.
- **`NUM_BUFS` = 2 stall:** one slot READING and the other READY, then `wr_req`.
  - Expect `wr_grant` = 0 until the reader finishes, then a grant of the freed slot exactly 1 cycle after it frees.
- **Same-edge event:** the writer's last pixel lands on the same edge as a reader grant of the old READY slot.
  - Expect the reader on the old slot, the new slot READY, and `drop_cnt` unchanged.

Source files
------------

// File: rtl/frame_buf_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_buf_sched: multi-slot frame ownership tracker and data_mem scheduler |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module frame_buf_sched #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_BUFS   = 3,
    parameter int BUF_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_req,
    input  logic                            wr_valid,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            wr_grant,
    input  logic                            rd_req,
    input  logic                            rd_en_in,
    output logic                            rd_grant,
    output logic                            mem_wr_en,
    output logic [BUF_WIDTH+ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]           mem_wr_data,
    output logic                            mem_rd_en,
    output logic [BUF_WIDTH+ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                            frame_ready,
    output logic [7:0]                      drop_cnt
);

    localparam int                    MEM_AW     = BUF_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_LAST_PIX = '1;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WRITING = 2'd1,
        SLOT_READY   = 2'd2,
        SLOT_READING = 2'd3
    } slot_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

    slot_t                   slot_q [NUM_BUFS];
    slot_t                   slot_d [NUM_BUFS];
    wr_state_t               wr_state_q;
    rd_state_t               rd_state_q;
    logic [BUF_WIDTH-1:0]    wr_slot_q;
    logic [BUF_WIDTH-1:0]    rd_slot_q;
    logic [ADDR_WIDTH-1:0]   wr_cnt_q;
    logic [ADDR_WIDTH-1:0]   rd_cnt_q;

    logic                    wr_grant_q;
    logic                    rd_grant_q;
    logic                    mem_wr_en_q;
    logic [MEM_AW-1:0]       mem_wr_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q;
    logic                    mem_rd_en_q;
    logic [MEM_AW-1:0]       mem_rd_addr_q;
    logic                    frame_ready_q;
    logic [7:0]              drop_cnt_q;

    logic                    w_any_free;
    logic                    w_any_ready;
    logic [BUF_WIDTH-1:0]    w_free_slot;
    logic [BUF_WIDTH-1:0]    w_ready_slot;
    logic                    w_wr_start;
    logic                    w_wr_pix;
    logic                    w_wr_last;
    logic                    w_rd_start;
    logic                    w_rd_pix;
    logic                    w_rd_last;
    logic                    w_drop;

    // Descending scan so the lowest-index FREE slot wins.
    always_comb begin
        w_any_free   = 1'b0;
        w_any_ready  = 1'b0;
        w_free_slot  = '0;
        w_ready_slot = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_FREE) begin
                w_any_free  = 1'b1;
                w_free_slot = BUF_WIDTH'(i);
            end
            if (slot_q[i] == SLOT_READY) begin
                w_any_ready  = 1'b1;
                w_ready_slot = BUF_WIDTH'(i);
            end
        end
    end

    assign w_wr_start = (wr_state_q == W_IDLE) && wr_req && w_any_free;
    assign w_wr_pix   = (wr_state_q == W_FILL) && wr_valid;
    assign w_wr_last  = w_wr_pix && (wr_cnt_q == C_LAST_PIX);
    assign w_rd_start = (rd_state_q == R_IDLE) && rd_req && w_any_ready;
    assign w_rd_pix   = (rd_state_q == R_READ) && rd_en_in;
    assign w_rd_last  = w_rd_pix && (rd_cnt_q == C_LAST_PIX);
    // An old READY frame claimed by the reader on this same edge is not stale.
    assign w_drop     = w_wr_last && w_any_ready && !w_rd_start;

    always_comb begin
        for (int i = 0; i < NUM_BUFS; i++) begin
            slot_d[i] = slot_q[i];
            if (w_wr_start && (w_free_slot == BUF_WIDTH'(i)))
                slot_d[i] = SLOT_WRITING;
            if (w_wr_last && (wr_slot_q == BUF_WIDTH'(i)))
                slot_d[i] = SLOT_READY;
            if (w_drop && (w_ready_slot == BUF_WIDTH'(i)))
                slot_d[i] = SLOT_FREE;
            if (w_rd_start && (w_ready_slot == BUF_WIDTH'(i)))
                slot_d[i] = SLOT_READING;
            if (w_rd_last && (rd_slot_q == BUF_WIDTH'(i)))
                slot_d[i] = SLOT_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUFS; i++) slot_q[i] <= SLOT_FREE;
            wr_state_q    <= W_IDLE;
            rd_state_q    <= R_IDLE;
            wr_slot_q     <= '0;
            rd_slot_q     <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            wr_grant_q    <= 1'b0;
            rd_grant_q    <= 1'b0;
            mem_wr_en_q   <= 1'b1;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            mem_rd_en_q   <= 1'b1;
            mem_rd_addr_q <= '0;
            frame_ready_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_BUFS; i++) slot_q[i] <= slot_d[i];

            if (wr_state_q == W_IDLE) begin
                if (w_wr_start) begin
                    wr_state_q <= W_FILL;
                    wr_slot_q  <= w_free_slot;
                    wr_cnt_q   <= '0;
                end
            end else if (w_wr_pix) begin
                wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
                if (w_wr_last) wr_state_q <= W_IDLE;
            end

            if (rd_state_q == R_IDLE) begin
                if (w_rd_start) begin
                    rd_state_q <= R_READ;
                    rd_slot_q  <= w_ready_slot;
                    rd_cnt_q   <= '0;
                end
            end else if (w_rd_pix) begin
                rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
                if (w_rd_last) rd_state_q <= R_IDLE;
            end

            wr_grant_q  <= w_wr_start;
            rd_grant_q  <= w_rd_start;
            mem_wr_en_q <= !w_wr_pix;
            mem_rd_en_q <= !w_rd_pix;
            if (w_wr_pix) begin
                mem_wr_addr_q <= {wr_slot_q, wr_cnt_q};
                mem_wr_data_q <= wr_data;
            end
            if (w_rd_pix) mem_rd_addr_q <= {rd_slot_q, rd_cnt_q};

            frame_ready_q <= w_any_ready;
            if (w_drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign wr_grant    = wr_grant_q;
    assign rd_grant    = rd_grant_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign frame_ready = frame_ready_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_buf_sched: directed bench for frame_buf_sched (3-slot and 2-slot) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_frame_buf_sched;

    logic        clk = 1'b0;
    logic        reset, wr_req, wr_valid, rd_req, rd_en_in;
    logic [23:0] wr_data;
    logic        wr_grant, rd_grant, mem_wr_en, mem_rd_en, frame_ready;
    logic [4:0]  mem_wr_addr, mem_rd_addr;
    logic [23:0] mem_wr_data;
    logic [7:0]  drop_cnt;

    logic        b_reset, b_wr_req, b_wr_valid, b_rd_req, b_rd_en_in;
    logic [23:0] b_wr_data;
    logic        b_wr_grant, b_rd_grant, b_mem_wr_en, b_mem_rd_en, b_frame_ready;
    logic [3:0]  b_mem_wr_addr, b_mem_rd_addr;
    logic [23:0] b_mem_wr_data;
    logic [7:0]  b_drop_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    frame_buf_sched #(.DATA_WIDTH(24), .ADDR_WIDTH(3), .NUM_BUFS(3), .BUF_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_grant(wr_grant), .rd_req(rd_req), .rd_en_in(rd_en_in), .rd_grant(rd_grant),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .frame_ready(frame_ready),
        .drop_cnt(drop_cnt)
    );

    frame_buf_sched #(.DATA_WIDTH(24), .ADDR_WIDTH(3), .NUM_BUFS(2), .BUF_WIDTH(1)) dut2 (
        .clk(clk), .reset(b_reset), .wr_req(b_wr_req), .wr_valid(b_wr_valid), .wr_data(b_wr_data),
        .wr_grant(b_wr_grant), .rd_req(b_rd_req), .rd_en_in(b_rd_en_in), .rd_grant(b_rd_grant),
        .mem_wr_en(b_mem_wr_en), .mem_wr_addr(b_mem_wr_addr), .mem_wr_data(b_mem_wr_data),
        .mem_rd_en(b_mem_rd_en), .mem_rd_addr(b_mem_rd_addr), .frame_ready(b_frame_ready),
        .drop_cnt(b_drop_cnt)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_req = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; rd_en_in = 1'b0;
        wr_data = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic write_frame(input logic [23:0] base);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        for (int p = 0; p < 8; p++) begin
            wr_valid = 1'b1;
            wr_data  = base + 24'(p);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wr_valid = 1'b1; wr_data = 24'h111100 + 24'(p);
            tick();
        end
        reset = 1'b1;
        tick(); tick();
        vec_cnt++;
        if (wr_grant !== 1'b0 || rd_grant !== 1'b0 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b1 ||
            mem_wr_addr !== 5'h00 || mem_rd_addr !== 5'h00 || mem_wr_data !== 24'h0 ||
            frame_ready !== 1'b0 || drop_cnt !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_values: got gr=%b/%b en=%b/%b wa=%h ra=%h wd=%h fr=%b dc=%h, required 0/0 1/1 00 00 000000 0 00",
                     wr_grant, rd_grant, mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr,
                     mem_wr_data, frame_ready, drop_cnt);
        end
        reset = 1'b0;
        wr_req = 1'b1;
        wr_data = 24'hABCDEF;
        tick();
        vec_cnt++;
        if (wr_grant !== 1'b1 || mem_wr_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_regrant: got grant=%b wr_en=%b, required 1 1", wr_grant, mem_wr_en);
        end
        wr_req = 1'b0;
        tick();
        vec_cnt++;
        if (mem_wr_en !== 1'b0 || mem_wr_addr !== 5'h00 || mem_wr_data !== 24'hABCDEF) begin
            err_cnt++;
            $display("FAIL reset_first_pixel: got en=%b addr=%h data=%h, required 0 00 abcdef",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_single_frame();
        do_reset();
        wr_req = 1'b1;
        tick();
        vec_cnt++;
        if (wr_grant !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_wr_grant: got %b, required 1", wr_grant);
        end
        wr_req = 1'b0;
        tick();
        vec_cnt++;
        if (wr_grant !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_wr_grant_pulse: got %b, required 0", wr_grant);
        end
        for (int p = 0; p < 8; p++) begin
            wr_valid = 1'b1; wr_data = 24'h500000 + 24'(p);
            tick();
            vec_cnt++;
            if (mem_wr_en !== 1'b0 || mem_wr_addr !== 5'(p) || mem_wr_data !== 24'h500000 + 24'(p)) begin
                err_cnt++;
                $display("FAIL single_write p=%0d: got en=%b addr=%h data=%h, required 0 %h %h",
                         p, mem_wr_en, mem_wr_addr, mem_wr_data, 5'(p), 24'h500000 + 24'(p));
            end
        end
        wr_valid = 1'b0;
        vec_cnt++;
        if (frame_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_ready_early: got %b, required 0", frame_ready);
        end
        tick();
        vec_cnt++;
        if (frame_ready !== 1'b1 || mem_wr_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_ready: got fr=%b wr_en=%b, required 1 1", frame_ready, mem_wr_en);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vec_cnt++;
        if (rd_grant !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_rd_grant: got %b, required 1", rd_grant);
        end
        for (int p = 0; p < 9; p++) begin
            rd_en_in = 1'b1;
            tick();
            vec_cnt++;
            if (p < 8 && (mem_rd_en !== 1'b0 || mem_rd_addr !== 5'(p))) begin
                err_cnt++;
                $display("FAIL single_read p=%0d: got en=%b addr=%h, required 0 %h", p, mem_rd_en, mem_rd_addr, 5'(p));
            end else if (p == 8 && mem_rd_en !== 1'b1) begin
                err_cnt++;
                $display("FAIL single_read_extra: got en=%b, required 1", mem_rd_en);
            end
        end
        rd_en_in = 1'b0;
        vec_cnt++;
        if (frame_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_ready_after_read: got %b, required 0", frame_ready);
        end
    endtask

    task automatic test_drop();
        do_reset();
        write_frame(24'hA00000);
        write_frame(24'hB00000);
        vec_cnt++;
        if (mem_wr_addr !== 5'h0F || drop_cnt !== 8'd1) begin
            err_cnt++;
            $display("FAIL drop_count: got last_addr=%h drop=%0d, required 0f 1", mem_wr_addr, drop_cnt);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vec_cnt++;
        if (rd_grant !== 1'b1) begin
            err_cnt++;
            $display("FAIL drop_rd_grant: got %b, required 1", rd_grant);
        end
        for (int p = 0; p < 8; p++) begin
            rd_en_in = 1'b1;
            tick();
            vec_cnt++;
            if (mem_rd_en !== 1'b0 || mem_rd_addr !== 5'h08 + 5'(p)) begin
                err_cnt++;
                $display("FAIL drop_read p=%0d: got en=%b addr=%h, required 0 %h", p, mem_rd_en, mem_rd_addr, 5'h08 + 5'(p));
            end
        end
        rd_en_in = 1'b0;
        write_frame(24'hC00000);
        vec_cnt++;
        if (mem_wr_addr !== 5'h07 || drop_cnt !== 8'd1) begin
            err_cnt++;
            $display("FAIL drop_slot0_free: got last_addr=%h drop=%0d, required 07 1", mem_wr_addr, drop_cnt);
        end
    endtask

    task automatic test_concurrent();
        int wsent, rsent, wseen, rseen;
        wsent = 0; rsent = 0; wseen = 0; rseen = 0;
        do_reset();
        write_frame(24'hD00000);
        tick();
        wr_req = 1'b1; rd_req = 1'b1;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        vec_cnt++;
        if (wr_grant !== 1'b1 || rd_grant !== 1'b1) begin
            err_cnt++;
            $display("FAIL conc_grants: got wr=%b rd=%b, required 1 1", wr_grant, rd_grant);
        end
        for (int c = 0; c < 200 && (wseen < 8 || rseen < 8); c++) begin
            wr_valid = (wsent < 8) && ($urandom_range(0, 1) == 1);
            rd_en_in = (rsent < 8) && ($urandom_range(0, 1) == 1);
            wr_data  = 24'hE00000 + 24'(wsent);
            if (wr_valid) wsent++;
            if (rd_en_in) rsent++;
            tick();
            if (mem_wr_en === 1'b0) begin
                vec_cnt++;
                if (mem_wr_addr !== {2'd1, 3'(wseen)} || mem_wr_data !== 24'hE00000 + 24'(wseen)) begin
                    err_cnt++;
                    $display("FAIL conc_write #%0d: got addr=%h data=%h, required %h %h",
                             wseen, mem_wr_addr, mem_wr_data, {2'd1, 3'(wseen)}, 24'hE00000 + 24'(wseen));
                end
                wseen++;
            end
            if (mem_rd_en === 1'b0) begin
                vec_cnt++;
                if (mem_rd_addr !== {2'd0, 3'(rseen)}) begin
                    err_cnt++;
                    $display("FAIL conc_read #%0d: got addr=%h, required %h", rseen, mem_rd_addr, {2'd0, 3'(rseen)});
                end
                rseen++;
            end
            if (mem_wr_en === 1'b0 && mem_rd_en === 1'b0) begin
                vec_cnt++;
                if (mem_wr_addr[4:3] === mem_rd_addr[4:3]) begin
                    err_cnt++;
                    $display("FAIL conc_collision: got wr_slot=%0d rd_slot=%0d, required different",
                             mem_wr_addr[4:3], mem_rd_addr[4:3]);
                end
            end
        end
        wr_valid = 1'b1; rd_en_in = 1'b1;
        tick();
        wr_valid = 1'b0; rd_en_in = 1'b0;
        vec_cnt++;
        if (wseen != 8 || rseen != 8 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b1 || drop_cnt !== 8'd0) begin
            err_cnt++;
            $display("FAIL conc_totals: got writes=%0d reads=%0d en=%b/%b drop=%0d, required 8 8 1/1 0",
                     wseen, rseen, mem_wr_en, mem_rd_en, drop_cnt);
        end
        vec_cnt++;
        if (frame_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL conc_ready: got %b, required 1", frame_ready);
        end
    endtask

    task automatic test_same_edge();
        do_reset();
        write_frame(24'hF00000);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        for (int p = 0; p < 8; p++) begin
            wr_valid = 1'b1; wr_data = 24'hF10000 + 24'(p);
            if (p == 7) rd_req = 1'b1;
            tick();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        vec_cnt++;
        if (rd_grant !== 1'b1 || drop_cnt !== 8'd0 || mem_wr_addr !== 5'h0F) begin
            err_cnt++;
            $display("FAIL same_edge_grant: got rd_grant=%b drop=%0d wa=%h, required 1 0 0f",
                     rd_grant, drop_cnt, mem_wr_addr);
        end
        rd_en_in = 1'b1;
        tick();
        rd_en_in = 1'b0;
        vec_cnt++;
        if (mem_rd_en !== 1'b0 || mem_rd_addr !== 5'h00 || frame_ready !== 1'b1 || drop_cnt !== 8'd0) begin
            err_cnt++;
            $display("FAIL same_edge_after: got en=%b ra=%h fr=%b drop=%0d, required 0 00 1 0",
                     mem_rd_en, mem_rd_addr, frame_ready, drop_cnt);
        end
    endtask

    task automatic test_stall_two_bufs();
        b_reset = 1'b1;
        tick(); tick();
        b_reset = 1'b0;
        b_wr_req = 1'b1;
        tick();
        b_wr_req = 1'b0;
        for (int p = 0; p < 8; p++) begin
            b_wr_valid = 1'b1; b_wr_data = 24'h200000 + 24'(p);
            tick();
        end
        b_wr_valid = 1'b0;
        b_wr_req = 1'b1; b_rd_req = 1'b1;
        tick();
        b_wr_req = 1'b0; b_rd_req = 1'b0;
        vec_cnt++;
        if (b_wr_grant !== 1'b1 || b_rd_grant !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_setup_grants: got wr=%b rd=%b, required 1 1", b_wr_grant, b_rd_grant);
        end
        for (int p = 0; p < 8; p++) begin
            b_wr_valid = 1'b1; b_wr_data = 24'h210000 + 24'(p);
            tick();
        end
        b_wr_valid = 1'b0;
        vec_cnt++;
        if (b_mem_wr_addr !== 4'hF) begin
            err_cnt++;
            $display("FAIL stall_second_slot: got last_addr=%h, required f", b_mem_wr_addr);
        end
        b_wr_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vec_cnt++;
            if (b_wr_grant !== 1'b0) begin
                err_cnt++;
                $display("FAIL stall_blocked c=%0d: got %b, required 0", c, b_wr_grant);
            end
        end
        for (int p = 0; p < 8; p++) begin
            b_rd_en_in = 1'b1;
            tick();
            vec_cnt++;
            if (b_wr_grant !== 1'b0 || b_mem_rd_addr !== 4'(p)) begin
                err_cnt++;
                $display("FAIL stall_during_read p=%0d: got grant=%b ra=%h, required 0 %h", p, b_wr_grant, b_mem_rd_addr, 4'(p));
            end
        end
        b_rd_en_in = 1'b0;
        tick();
        vec_cnt++;
        if (b_wr_grant !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_release: got %b, required 1", b_wr_grant);
        end
        b_wr_req = 1'b0;
        b_wr_valid = 1'b1; b_wr_data = 24'h220000;
        tick();
        b_wr_valid = 1'b0;
        vec_cnt++;
        if (b_mem_wr_en !== 1'b0 || b_mem_wr_addr !== 4'h0) begin
            err_cnt++;
            $display("FAIL stall_freed_slot: got en=%b addr=%h, required 0 0", b_mem_wr_en, b_mem_wr_addr);
        end
    endtask

    initial begin
        reset = 1'b1; wr_req = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; rd_en_in = 1'b0; wr_data = '0;
        b_reset = 1'b1; b_wr_req = 1'b0; b_wr_valid = 1'b0; b_rd_req = 1'b0; b_rd_en_in = 1'b0;
        b_wr_data = '0;
        test_reset();
        test_single_frame();
        test_drop();
        test_concurrent();
        test_same_edge();
        test_stall_two_bufs();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
